// File: rtl/fb_pkg.sv
// Shared constants, read-FSM state type and pixel extraction helper for the frame-buffer scan-out block.
// Pure declarations: no latency, no backpressure.
package fb_pkg;

  localparam int PIXEL_W                 = 2;
  localparam int PIXELS_PER_BYTE         = 4;
  localparam int DEFAULT_PIXELS_PER_LINE = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } rdState_t;

  // Pixel 0 is the leftmost one and sits in the top two bits of the byte.
  function automatic logic [PIXEL_W-1:0] pixelOf(input logic [7:0] b, input logic [1:0] k);
    logic [PIXEL_W-1:0] p;
    p = b[7:6];
    case (k)
      2'd0: p = b[7:6];
      2'd1: p = b[5:4];
      2'd2: p = b[3:2];
      2'd3: p = b[1:0];
      default: p = b[7:6];
    endcase
    return p;
  endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// Two-bank frame store, one write port and one synchronous read port (1-cycle read latency).
// No backpressure: every write and every read enable is taken; contents are not reset.
module fb_bank_ram #(
  parameter int ADDR_W = 8
) (
  input  logic            clock,
  input  logic            we,
  input  logic [ADDR_W:0] wrAddr,
  input  logic [7:0]      wrData,
  input  logic            rdEn,
  input  logic [ADDR_W:0] rdAddr,
  output logic [7:0]      rdData
);

  logic [7:0] mem [0:(2**(ADDR_W+1))-1];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[wrAddr] <= wrData;
    end
    if (rdEn) begin
      rdData <= mem[rdAddr];
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// Ping-pong frame-buffer sink that streams completed frames as 2-bit pixels; first pixel 2 edges after completion.
// Writer never stalls (blocked frames are overwritten, flagged by oOverrun); pixel stream holds while iPixelReady is low.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int PIXELS_PER_LINE = DEFAULT_PIXELS_PER_LINE,
  parameter int ADDR_W          = 8
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iFrameBufferWe,
  input  logic [7:0]         iFrameBufferData,
  input  logic [ADDR_W-1:0]  iFrameBufferAddr,
  output logic [PIXEL_W-1:0] oPixel,
  output logic               oPixelValid,
  input  logic               iPixelReady,
  output logic               oFrameStart,
  output logic               oLineEnd,
  output logic [1:0]         oBankFull,
  output logic               oOverrun
);

  localparam int                BYTES_PER_LINE = PIXELS_PER_LINE / PIXELS_PER_BYTE;
  localparam logic [ADDR_W-1:0] LAST_ADDR      = '1;
  localparam logic [ADDR_W-1:0] LINE_MASK      = ADDR_W'(BYTES_PER_LINE - 1);

  rdState_t          state, stateNext;
  logic [ADDR_W-1:0] rdAddr, rdAddrNext;
  logic [1:0]        pixIdx, pixIdxNext;
  logic              wBank, wBankNext;
  logic              rBank, rBankNext;
  logic [1:0]        full, fullNext;
  logic              midFrame, midFrameNext;
  logic              overrun, overrunNext;
  logic [7:0]        q;
  logic              fetchEn;
  logic              relBank;
  logic              complete;
  logic              readerBusy;

  assign complete  = iFrameBufferWe && (iFrameBufferAddr == LAST_ADDR);
  assign oBankFull = full;
  assign oOverrun  = overrun;

  fb_bank_ram #(
    .ADDR_W(ADDR_W)
  ) uRam (
    .clock (iClock),
    .we    (iFrameBufferWe),
    .wrAddr({wBank, iFrameBufferAddr}),
    .wrData(iFrameBufferData),
    .rdEn  (fetchEn),
    .rdAddr({rBank, rdAddr}),
    .rdData(q)
  );

  // Read FSM: one FETCH bubble per byte, then four SEND beats.
  always_comb begin
    stateNext   = state;
    rdAddrNext  = rdAddr;
    pixIdxNext  = pixIdx;
    fetchEn     = 1'b0;
    relBank     = 1'b0;
    oPixelValid = 1'b0;
    oPixel      = '0;
    oFrameStart = 1'b0;
    oLineEnd    = 1'b0;
    case (state)
      IDLE: begin
        // A bank the writer has re-entered mid-frame is off limits until it completes again.
        if (full[rBank] && !(rBank == wBank && midFrame)) begin
          stateNext  = FETCH;
          rdAddrNext = '0;
        end
      end
      FETCH: begin
        fetchEn    = 1'b1;
        stateNext  = SEND;
        pixIdxNext = '0;
      end
      SEND: begin
        oPixelValid = 1'b1;
        oPixel      = pixelOf(q, pixIdx);
        oFrameStart = (rdAddr == '0) && (pixIdx == 2'd0);
        oLineEnd    = (pixIdx == 2'd3) && ((rdAddr & LINE_MASK) == LINE_MASK);
        if (iPixelReady) begin
          if (pixIdx != 2'd3) begin
            pixIdxNext = pixIdx + 2'd1;
          end else if (rdAddr != LAST_ADDR) begin
            rdAddrNext = rdAddr + 1'b1;
            stateNext  = FETCH;
          end else begin
            relBank   = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Bank bookkeeping: the reader's release is applied before the writer's completion.
  always_comb begin
    fullNext     = full;
    wBankNext    = wBank;
    rBankNext    = rBank;
    midFrameNext = midFrame;
    overrunNext  = 1'b0;
    readerBusy   = (state != IDLE) && !relBank;
    if (relBank) begin
      fullNext[rBank] = 1'b0;
      rBankNext       = ~rBank;
    end
    if (complete) begin
      overrunNext     = fullNext[wBank];
      fullNext[wBank] = 1'b1;
      midFrameNext    = 1'b0;
      if (!fullNext[~wBank] && !(readerBusy && rBank != wBank)) begin
        wBankNext = ~wBank;
      end
    end else begin
      if (iFrameBufferWe) begin
        midFrameNext = 1'b1;
      end
      // A writer parked on its completed frame moves into the bank the reader just freed.
      if (relBank && !midFrame && full[wBank] && rBank != wBank) begin
        wBankNext = ~wBank;
      end
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state    <= IDLE;
      rdAddr   <= '0;
      pixIdx   <= '0;
      wBank    <= 1'b0;
      rBank    <= 1'b0;
      full     <= '0;
      midFrame <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= stateNext;
      rdAddr   <= rdAddrNext;
      pixIdx   <= pixIdxNext;
      wBank    <= wBankNext;
      rBank    <= rBankNext;
      full     <= fullNext;
      midFrame <= midFrameNext;
      overrun  <= overrunNext;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: pixel table, latency, backpressure hold, overrun, reset and same-edge release.
module tb_fb_scanout;

  logic       iClock = 1'b0;
  logic       iReset = 1'b0;
  logic       iFrameBufferWe = 1'b0;
  logic [7:0] iFrameBufferData = 8'h00;
  logic [7:0] iFrameBufferAddr = 8'h00;
  logic       iPixelReady = 1'b0;
  logic [1:0] oPixel;
  logic       oPixelValid, oFrameStart, oLineEnd, oOverrun;
  logic [1:0] oBankFull;

  logic       ready64 = 1'b1;
  logic [1:0] pix64, bf64;
  logic       pv64, fs64, le64, ov64;

  typedef struct {
    int         idx;
    logic [1:0] pix;
    logic       fs;
    logic       le;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  int         readyMode = 0;
  logic [7:0] expMem [256];
  logic [1:0] pixQ [$];
  logic       fsQ [$];
  logic       leQ [$];
  logic [1:0] p64Q [$];
  logic       le64Q [$];
  bit         rec64 = 1'b0;
  int         fs64Cnt = 0;
  int         ovCnt = 0;
  int         holdErrs = 0;
  logic       stallPrev = 1'b0;
  logic [1:0] heldPix = 2'b00;
  logic       heldFs = 1'b0;
  logic       heldLe = 1'b0;

  fb_scanout dut (
    .iClock(iClock), .iReset(iReset), .iFrameBufferWe(iFrameBufferWe),
    .iFrameBufferData(iFrameBufferData), .iFrameBufferAddr(iFrameBufferAddr),
    .oPixel(oPixel), .oPixelValid(oPixelValid), .iPixelReady(iPixelReady),
    .oFrameStart(oFrameStart), .oLineEnd(oLineEnd), .oBankFull(oBankFull), .oOverrun(oOverrun)
  );

  fb_scanout #(.PIXELS_PER_LINE(64)) dut64 (
    .iClock(iClock), .iReset(iReset), .iFrameBufferWe(iFrameBufferWe),
    .iFrameBufferData(iFrameBufferData), .iFrameBufferAddr(iFrameBufferAddr),
    .oPixel(pix64), .oPixelValid(pv64), .iPixelReady(ready64),
    .oFrameStart(fs64), .oLineEnd(le64), .oBankFull(bf64), .oOverrun(ov64)
  );

  always #5 iClock = ~iClock;

  always @(posedge iClock) begin
    #1;
    case (readyMode)
      0:       iPixelReady = 1'b0;
      1:       iPixelReady = 1'b1;
      default: iPixelReady = 1'($urandom_range(0, 1));
    endcase
  end

  // Mid-cycle monitor: a Valid&Ready seen here is the handshake of the next rising edge.
  always @(negedge iClock) begin
    if (oPixelValid && iPixelReady) begin
      pixQ.push_back(oPixel);
      fsQ.push_back(oFrameStart);
      leQ.push_back(oLineEnd);
    end
    if (rec64 && pv64) begin
      p64Q.push_back(pix64);
      le64Q.push_back(le64);
      if (fs64) fs64Cnt++;
    end
    if (oOverrun) ovCnt++;
    if (stallPrev && (oPixelValid !== 1'b1 || oPixel !== heldPix ||
                      oFrameStart !== heldFs || oLineEnd !== heldLe)) holdErrs++;
    stallPrev = oPixelValid && !iPixelReady;
    heldPix   = oPixel;
    heldFs    = oFrameStart;
    heldLe    = oLineEnd;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic setPattern(input int mode, input logic [7:0] v);
    for (int a = 0; a < 256; a++)
      expMem[a] = (mode == 0) ? 8'(a) : (mode == 1) ? v : (8'(a) ^ v);
  endtask

  task automatic writeRange(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      @(posedge iClock); #1;
      iFrameBufferWe   = 1'b1;
      iFrameBufferAddr = 8'(a);
      iFrameBufferData = expMem[a];
    end
    @(posedge iClock); #1;
    iFrameBufferWe = 1'b0;
  endtask

  task automatic clearQ();
    pixQ.delete();
    fsQ.delete();
    leQ.delete();
  endtask

  task automatic waitPix(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (pixQ.size() < n && c < budget) begin
      @(negedge iClock); #1;
      c++;
    end
    check(name, pixQ.size(), n);
  endtask

  task automatic checkFrame(input int off, input int ppl, input string name);
    int pe, fe, le;
    logic [7:0] b;
    logic [1:0] e;
    pe = 0; fe = 0; le = 0;
    if (pixQ.size() < off + 1024) begin
      check({name, "_len"}, pixQ.size(), off + 1024);
      return;
    end
    for (int i = 0; i < 1024; i++) begin
      b = expMem[i / 4];
      e = 2'((b >> (6 - 2 * (i % 4))) & 8'h03);
      if (pixQ[off + i] !== e) pe++;
      if (fsQ[off + i] !== (i == 0)) fe++;
      if (leQ[off + i] !== ((i % ppl) == ppl - 1)) le++;
    end
    check({name, "_pix_errs"}, pe, 0);
    check({name, "_fs_errs"}, fe, 0);
    check({name, "_le_errs"}, le, 0);
  endtask

  initial begin
    vec_t tbl [14];
    int   errs, errsLe, seen;
    bit   hit;

    tbl[0]  = '{0,    2'd0, 1'b1, 1'b0};
    tbl[1]  = '{3,    2'd0, 1'b0, 1'b0};
    tbl[2]  = '{4,    2'd0, 1'b0, 1'b0};
    tbl[3]  = '{7,    2'd1, 1'b0, 1'b0};
    tbl[4]  = '{30,   2'd1, 1'b0, 1'b0};
    tbl[5]  = '{31,   2'd3, 1'b0, 1'b1};
    tbl[6]  = '{32,   2'd0, 1'b0, 1'b0};
    tbl[7]  = '{34,   2'd2, 1'b0, 1'b0};
    tbl[8]  = '{101,  2'd1, 1'b0, 1'b0};
    tbl[9]  = '{102,  2'd2, 1'b0, 1'b0};
    tbl[10] = '{512,  2'd2, 1'b0, 1'b0};
    tbl[11] = '{764,  2'd2, 1'b0, 1'b0};
    tbl[12] = '{767,  2'd3, 1'b0, 1'b1};
    tbl[13] = '{1023, 2'd3, 1'b0, 1'b1};

    repeat (3) @(posedge iClock);
    @(negedge iClock); #1;
    check("reset_outs", {oPixel, oPixelValid, oFrameStart, oLineEnd, oBankFull, oOverrun}, 0);
    @(posedge iClock); #1;
    iReset = 1'b1;

    // Incrementing frame, Ready held high
    readyMode = 1;
    rec64 = 1'b1;
    setPattern(0, 8'h00);
    writeRange(0, 255);
    @(negedge iClock); #1;
    check("t1_full_e0", oBankFull, 2'b01);
    check("t1_valid_e0", oPixelValid, 0);
    @(negedge iClock); #1;
    check("t1_valid_e1", oPixelValid, 0);
    @(negedge iClock); #1;
    check("t1_valid_e2", oPixelValid, 1);
    check("t1_fs_e2", oFrameStart, 1);
    waitPix(1024, 3000, "t1_count");
    repeat (3) @(negedge iClock);
    #1;
    check("t1_full_after", oBankFull, 2'b00);
    for (int i = 0; i < 14; i++) begin
      if (pixQ.size() > tbl[i].idx) begin
        check($sformatf("t1_tbl%0d_pix", tbl[i].idx), pixQ[tbl[i].idx], tbl[i].pix);
        check($sformatf("t1_tbl%0d_fs", tbl[i].idx), fsQ[tbl[i].idx], tbl[i].fs);
        check($sformatf("t1_tbl%0d_le", tbl[i].idx), leQ[tbl[i].idx], tbl[i].le);
      end else begin
        check($sformatf("t1_tbl%0d_present", tbl[i].idx), pixQ.size(), tbl[i].idx + 1);
      end
    end
    checkFrame(0, 32, "t1");

    // 64-pixel-line build saw the same writes
    rec64 = 1'b0;
    check("t6_count", p64Q.size(), 1024);
    check("t6_fs_count", fs64Cnt, 1);
    check("t6_flags", {bf64, ov64}, 0);
    errs = 0; errsLe = 0;
    if (p64Q.size() >= 1024) begin
      for (int i = 0; i < 1024; i++) begin
        if (p64Q[i] !== pixQ[i]) errs++;
        if (le64Q[i] !== ((i % 64) == 63)) errsLe++;
      end
    end
    check("t6_pix_errs", errs, 0);
    check("t6_le_errs", errsLe, 0);

    // Random Ready during a frame
    clearQ();
    readyMode = 2;
    setPattern(2, 8'h5A);
    writeRange(0, 255);
    waitPix(1024, 6000, "t2_count");
    checkFrame(0, 32, "t2");
    repeat (4) @(negedge iClock);
    #1;
    check("t2_no_extra", pixQ.size(), 1024);

    // Frames A, B, C with the reader stalled
    readyMode = 0;
    repeat (3) @(posedge iClock);
    clearQ();
    check("t3_ovr_start", ovCnt, 0);
    setPattern(1, 8'hAA);
    writeRange(0, 255);
    @(negedge iClock); #1;
    check("t3_full_A", oBankFull, 2'b01);
    setPattern(1, 8'h55);
    writeRange(0, 255);
    @(negedge iClock); #1;
    check("t3_full_B", oBankFull, 2'b11);
    check("t3_no_ovr_B", ovCnt, 0);
    setPattern(1, 8'hFF);
    writeRange(0, 255);
    @(negedge iClock); #1;
    check("t3_ovr_pulse", oOverrun, 1);
    @(negedge iClock); #1;
    check("t3_ovr_gone", oOverrun, 0);
    check("t3_ovr_count", ovCnt, 1);
    readyMode = 1;
    waitPix(2048, 6000, "t3_count");
    setPattern(1, 8'hAA);
    checkFrame(0, 32, "t3_A");
    setPattern(1, 8'hFF);
    checkFrame(1024, 32, "t3_C");
    repeat (20) @(negedge iClock);
    #1;
    check("t3_no_B", pixQ.size(), 2048);
    check("t3_full_end", oBankFull, 2'b00);

    // Reset halfway through a frame
    clearQ();
    setPattern(2, 8'hC6);
    writeRange(0, 255);
    waitPix(512, 1500, "t4_half");
    @(posedge iClock); #1;
    iReset = 1'b0;
    @(negedge iClock); #1;
    check("t4_reset_outs", {oPixel, oPixelValid, oFrameStart, oLineEnd, oBankFull, oOverrun}, 0);
    repeat (2) @(posedge iClock);
    #1;
    iReset = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge iClock); #1;
      if (oPixelValid) seen++;
    end
    check("t4_idle_after_reset", seen, 0);
    setPattern(2, 8'h3C);
    writeRange(0, 254);
    seen = 0;
    repeat (10) begin
      @(negedge iClock); #1;
      if (oPixelValid) seen++;
    end
    check("t4_idle_partial", seen, 0);
    clearQ();
    writeRange(255, 255);
    @(negedge iClock); #1;
    check("t4_full_e0", oBankFull, 2'b01);
    check("t4_valid_e0", oPixelValid, 0);
    @(negedge iClock); #1;
    check("t4_valid_e1", oPixelValid, 0);
    @(negedge iClock); #1;
    check("t4_valid_e2", oPixelValid, 1);
    waitPix(1024, 3000, "t4_count");
    checkFrame(0, 32, "t4");

    // Last handshake of bank 0 on the same edge as the completing write to bank 1
    readyMode = 0;
    @(posedge iClock); #1;
    iReset = 1'b0;
    repeat (2) @(posedge iClock);
    #1;
    iReset = 1'b1;
    setPattern(1, 8'h1B);
    writeRange(0, 255);
    setPattern(2, 8'hE1);
    writeRange(0, 254);
    clearQ();
    readyMode = 1;
    hit = 1'b0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(negedge iClock); #1;
      if (pixQ.size() >= 1024) hit = 1'b1;
    end
    check("t5_sync", hit, 1);
    iFrameBufferWe   = 1'b1;
    iFrameBufferAddr = 8'hFF;
    iFrameBufferData = expMem[255];
    @(posedge iClock); #1;
    iFrameBufferWe = 1'b0;
    @(negedge iClock); #1;
    check("t5_no_ovr", oOverrun, 0);
    check("t5_full", oBankFull, 2'b10);
    check("t5_valid_e0", oPixelValid, 0);
    clearQ();
    @(negedge iClock); #1;
    check("t5_valid_e1", oPixelValid, 0);
    @(negedge iClock); #1;
    check("t5_valid_e2", oPixelValid, 1);
    check("t5_fs_e2", oFrameStart, 1);
    waitPix(1024, 3000, "t5_count");
    checkFrame(0, 32, "t5");
    check("t5_ovr_count", ovCnt, 1);

    check("hold_stable", holdErrs, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
